// File: rtl/trig_pkg.sv
// Shared constants, quadrant encoding and the quarter-wave table generator
// used by the trig_pipe sine/cosine pipeline.
package trig_pkg;

    localparam int DEG_FULL    = 360;
    localparam int DEG_QUARTER = 90;
    localparam int QTAB_DEPTH  = 91;

    typedef enum logic [1:0] {Q0, Q1, Q2, Q3} quadrant_t;

    // round(sin(k deg) * 2^frac_w). The Taylor series keeps elaboration
    // independent of tool support for $sin; 12 terms are far below 1 LSB at pi/2.
    function automatic int qtab_value(input int k, input int frac_w);
        real x;
        real term;
        real acc;
        real scale;
        x    = real'(k) * 3.14159265358979323846 / 180.0;
        term = x;
        acc  = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        scale = 1.0;
        for (int i = 0; i < frac_w; i++) begin
            scale = scale * 2.0;
        end
        return $rtoi(acc * scale + 0.5);
    endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// 91-entry quarter-wave sine table with two independent registered read ports
// sharing one enable, so both lookups advance together with the pipeline.
module quarter_sine_rom
    import trig_pkg::*;
#(
    parameter int OUT_W  = 32,
    parameter int FRAC_W = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             en_in,
    input  logic [6:0]       sin_idx_in,
    input  logic [6:0]       cos_idx_in,
    output logic [OUT_W-1:0] sin_val_out,
    output logic [OUT_W-1:0] cos_val_out
);

    logic [OUT_W-1:0] tab [QTAB_DEPTH];
    logic [OUT_W-1:0] sin_val_q;
    logic [OUT_W-1:0] cos_val_q;

    for (genvar k = 0; k < QTAB_DEPTH; k++) begin : g_tab
        localparam logic [OUT_W-1:0] VAL = OUT_W'(qtab_value(k, FRAC_W));
        assign tab[k] = VAL;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sin_val_q <= '0;
            cos_val_q <= '0;
        end else if (en_in) begin
            sin_val_q <= (sin_idx_in < 7'(QTAB_DEPTH)) ? tab[sin_idx_in] : '0;
            cos_val_q <= (cos_idx_in < 7'(QTAB_DEPTH)) ? tab[cos_idx_in] : '0;
        end
    end

    assign sin_val_out = sin_val_q;
    assign cos_val_out = cos_val_q;

endmodule

// File: rtl/trig_pipe.sv
// Three-stage sine/cosine generator (reduce, lookup, sign) for integer-degree
// angles with valid/ready handshake; a single global stall holds every stage.
module trig_pipe
    import trig_pkg::*;
#(
    parameter int ANGLE_W = 9,
    parameter int OUT_W   = 32,
    parameter int FRAC_W  = 16,
    parameter int TAG_W   = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [ANGLE_W-1:0] angle_in,
    input  logic [TAG_W-1:0]   tag_in,
    input  logic               valid_in,
    output logic               ready_out,
    output logic [OUT_W-1:0]   sin_out,
    output logic [OUT_W-1:0]   cos_out,
    output logic [TAG_W-1:0]   tag_out,
    output logic               valid_out,
    input  logic               ready_in
);

    localparam int NSUB = ((2 ** ANGLE_W) - 1) / DEG_FULL;

    logic             en;
    logic [ANGLE_W-1:0] red;
    logic [8:0]       a_d, a_q;
    quadrant_t        quad_d, quad_q;
    logic [TAG_W-1:0] tag1_q, tag2_q, tag3_q;
    logic             v1_q, v2_q, v3_q;
    logic [6:0]       sin_idx, cos_idx;
    logic             sin_neg_d, cos_neg_d, sin_neg_q, cos_neg_q;
    logic [OUT_W-1:0] sin_t, cos_t;
    logic [OUT_W-1:0] sin_d, cos_d, sin_q, cos_q;

    assign en        = !(v3_q && !ready_in);
    assign ready_out = en;

    always_comb begin
        red = angle_in;
        for (int i = 0; i < NSUB; i++) begin
            if (red >= ANGLE_W'(DEG_FULL)) red = red - ANGLE_W'(DEG_FULL);
        end
        a_d = red[8:0];
        if (a_d < 9'd90)       quad_d = Q0;
        else if (a_d < 9'd180) quad_d = Q1;
        else if (a_d < 9'd270) quad_d = Q2;
        else                   quad_d = Q3;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            a_q    <= '0;
            quad_q <= Q0;
            tag1_q <= '0;
            v1_q   <= 1'b0;
        end else if (en) begin
            a_q    <= a_d;
            quad_q <= quad_d;
            tag1_q <= tag_in;
            v1_q   <= valid_in;
        end
    end

    // Fold each quadrant onto 0..90 so one quarter table serves both outputs.
    always_comb begin
        sin_idx   = 7'(a_q);
        cos_idx   = 7'(9'd90 - a_q);
        sin_neg_d = 1'b0;
        cos_neg_d = 1'b0;
        case (quad_q)
            Q0: begin
                sin_idx = 7'(a_q);
                cos_idx = 7'(9'd90 - a_q);
            end
            Q1: begin
                sin_idx   = 7'(9'd180 - a_q);
                cos_idx   = 7'(a_q - 9'd90);
                cos_neg_d = 1'b1;
            end
            Q2: begin
                sin_idx   = 7'(a_q - 9'd180);
                cos_idx   = 7'(9'd270 - a_q);
                sin_neg_d = 1'b1;
                cos_neg_d = 1'b1;
            end
            Q3: begin
                sin_idx   = 7'(9'd360 - a_q);
                cos_idx   = 7'(a_q - 9'd270);
                sin_neg_d = 1'b1;
            end
            default: ;
        endcase
    end

    quarter_sine_rom #(
        .OUT_W  (OUT_W),
        .FRAC_W (FRAC_W)
    ) u_rom (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .en_in       (en),
        .sin_idx_in  (sin_idx),
        .cos_idx_in  (cos_idx),
        .sin_val_out (sin_t),
        .cos_val_out (cos_t)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sin_neg_q <= 1'b0;
            cos_neg_q <= 1'b0;
            tag2_q    <= '0;
            v2_q      <= 1'b0;
        end else if (en) begin
            sin_neg_q <= sin_neg_d;
            cos_neg_q <= cos_neg_d;
            tag2_q    <= tag1_q;
            v2_q      <= v1_q;
        end
    end

    // Table entries are non-negative, so a true negate keeps -0 at 0.
    always_comb begin
        sin_d = sin_neg_q ? (~sin_t + OUT_W'(1)) : sin_t;
        cos_d = cos_neg_q ? (~cos_t + OUT_W'(1)) : cos_t;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sin_q  <= '0;
            cos_q  <= '0;
            tag3_q <= '0;
            v3_q   <= 1'b0;
        end else if (en) begin
            sin_q  <= sin_d;
            cos_q  <= cos_d;
            tag3_q <= tag2_q;
            v3_q   <= v2_q;
        end
    end

    assign sin_out   = sin_q;
    assign cos_out   = cos_q;
    assign tag_out   = tag3_q;
    assign valid_out = v3_q;

endmodule

// File: tb/tb_trig_pipe.sv
// Directed bench for trig_pipe: latency, quadrant signs, wrap, back-to-back
// streaming, random backpressure and asynchronous reset with samples in flight.
module tb_trig_pipe;

    localparam int ANGLE_W = 9;
    localparam int OUT_W   = 32;
    localparam int FRAC_W  = 16;
    localparam int TAG_W   = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [ANGLE_W-1:0] angle_in;
    logic [TAG_W-1:0]   tag_in;
    logic               valid_in;
    logic               ready_out;
    logic [OUT_W-1:0]   sin_out;
    logic [OUT_W-1:0]   cos_out;
    logic [TAG_W-1:0]   tag_out;
    logic               valid_out;
    logic               ready_in;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    trig_pipe #(
        .ANGLE_W (ANGLE_W),
        .OUT_W   (OUT_W),
        .FRAC_W  (FRAC_W),
        .TAG_W   (TAG_W)
    ) dut (
        .clk_in    (clk),
        .rst_in    (rst),
        .angle_in  (angle_in),
        .tag_in    (tag_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .sin_out   (sin_out),
        .cos_out   (cos_out),
        .tag_out   (tag_out),
        .valid_out (valid_out),
        .ready_in  (ready_in)
    );

    task automatic test_reset();
        rst      = 1'b1;
        valid_in = 1'b0;
        ready_in = 1'b1;
        angle_in = '0;
        tag_in   = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_out); end
        n_checks++;
        if (ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready_out); end
        n_checks++;
        if (sin_out !== 32'h0) begin n_fail++; $display("FAIL reset_sin got %h want 0", sin_out); end
        n_checks++;
        if (cos_out !== 32'h0) begin n_fail++; $display("FAIL reset_cos got %h want 0", cos_out); end
        n_checks++;
        if (tag_out !== 4'h0) begin n_fail++; $display("FAIL reset_tag got %h want 0", tag_out); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single(input logic [8:0] ang, input logic [3:0] tg,
                               input logic [31:0] es, input logic [31:0] ec, input string name);
        ready_in = 1'b1;
        valid_in = 1'b1;
        angle_in = ang;
        tag_in   = tg;
        @(negedge clk);
        valid_in = 1'b0;
        n_checks++;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL %s_lat1 valid got %b want 0", name, valid_out); end
        @(negedge clk);
        n_checks++;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL %s_lat2 valid got %b want 0", name, valid_out); end
        @(negedge clk);
        n_checks++;
        if (valid_out !== 1'b1) begin n_fail++; $display("FAIL %s_valid got %b want 1", name, valid_out); end
        n_checks++;
        if (sin_out !== es) begin n_fail++; $display("FAIL %s_sin got %h want %h", name, sin_out, es); end
        n_checks++;
        if (cos_out !== ec) begin n_fail++; $display("FAIL %s_cos got %h want %h", name, cos_out, ec); end
        n_checks++;
        if (tag_out !== tg) begin n_fail++; $display("FAIL %s_tag got %h want %h", name, tag_out, tg); end
        @(negedge clk);
        n_checks++;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL %s_drain valid got %b want 0", name, valid_out); end
    endtask

    task automatic test_back_to_back();
        logic [8:0]  angs [4] = '{9'd0, 9'd90, 9'd180, 9'd270};
        logic [31:0] es   [4] = '{32'h0, 32'h00010000, 32'h0, 32'hFFFF0000};
        logic [31:0] ec   [4] = '{32'h00010000, 32'h0, 32'hFFFF0000, 32'h0};
        ready_in = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i >= 3) begin
                n_checks++;
                if (valid_out !== 1'b1) begin n_fail++; $display("FAIL b2b%0d_valid got %b want 1", i - 3, valid_out); end
                n_checks++;
                if (sin_out !== es[i-3]) begin n_fail++; $display("FAIL b2b%0d_sin got %h want %h", i - 3, sin_out, es[i-3]); end
                n_checks++;
                if (cos_out !== ec[i-3]) begin n_fail++; $display("FAIL b2b%0d_cos got %h want %h", i - 3, cos_out, ec[i-3]); end
            end
            if (i < 4) begin
                valid_in = 1'b1;
                angle_in = angs[i];
                tag_in   = 4'(i + 8);
            end else begin
                valid_in = 1'b0;
            end
            @(negedge clk);
        end
        n_checks++;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL b2b_drain valid got %b want 0", valid_out); end
    endtask

    task automatic test_backpressure();
        logic [8:0]  angs [8] = '{9'd0, 9'd30, 9'd90, 9'd150, 9'd180, 9'd210, 9'd320, 9'd400};
        logic [31:0] es   [8] = '{32'h0, 32'h00008000, 32'h00010000, 32'h00008000,
                                  32'h0, 32'hFFFF8000, 32'hFFFF5B72, 32'h0000A48E};
        logic [31:0] ec   [8] = '{32'h00010000, 32'h0000DDB4, 32'h0, 32'hFFFF224C,
                                  32'hFFFF0000, 32'hFFFF224C, 32'h0000C41B, 32'h0000C41B};
        logic [7:0]  lfsr = 8'hA5;
        int          in_idx = 0;
        int          out_idx = 0;
        int          cyc = 0;
        logic        stalled_prev = 1'b0;
        logic [31:0] sv_sin = '0;
        logic [31:0] sv_cos = '0;
        logic [3:0]  sv_tag = '0;
        while (out_idx < 8 && cyc < 300) begin
            if (stalled_prev) begin
                n_checks++;
                if (valid_out !== 1'b1 || sin_out !== sv_sin || cos_out !== sv_cos || tag_out !== sv_tag) begin
                    n_fail++;
                    $display("FAIL bp_hold got v=%b %h %h %h want v=1 %h %h %h",
                             valid_out, sin_out, cos_out, tag_out, sv_sin, sv_cos, sv_tag);
                end
            end
            ready_in = lfsr[0];
            lfsr     = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            valid_in = (in_idx < 8);
            if (in_idx < 8) begin
                angle_in = angs[in_idx];
                tag_in   = 4'(in_idx);
            end
            #1;
            n_checks++;
            if (ready_out !== !(valid_out && !ready_in)) begin
                n_fail++;
                $display("FAIL bp_ready got %b want %b", ready_out, !(valid_out && !ready_in));
            end
            if (valid_out && ready_in) begin
                n_checks++;
                if (sin_out !== es[out_idx] || cos_out !== ec[out_idx] || tag_out !== 4'(out_idx)) begin
                    n_fail++;
                    $display("FAIL bp_out%0d got %h %h tag %h want %h %h tag %h",
                             out_idx, sin_out, cos_out, tag_out, es[out_idx], ec[out_idx], 4'(out_idx));
                end
                out_idx++;
            end
            stalled_prev = valid_out && !ready_in;
            sv_sin = sin_out;
            sv_cos = cos_out;
            sv_tag = tag_out;
            if (valid_in && ready_out) in_idx++;
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (out_idx != 8) begin n_fail++; $display("FAIL bp_timeout got %0d outputs want 8", out_idx); end
        valid_in = 1'b0;
        ready_in = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (valid_out !== 1'b0) begin n_fail++; $display("FAIL bp_extra%0d valid got %b want 0", i, valid_out); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_inflight();
        ready_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            valid_in = 1'b1;
            angle_in = 9'(30 * (i + 1));
            tag_in   = 4'(i + 1);
            @(negedge clk);
        end
        valid_in = 1'b0;
        n_checks++;
        if (valid_out !== 1'b1) begin n_fail++; $display("FAIL rst_pre valid got %b want 1", valid_out); end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_async valid got %b want 0", valid_out); end
        n_checks++;
        if (ready_out !== 1'b1) begin n_fail++; $display("FAIL rst_async ready got %b want 1", ready_out); end
        n_checks++;
        if (sin_out !== 32'h0) begin n_fail++; $display("FAIL rst_async sin got %h want 0", sin_out); end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_checks++;
            if (valid_out !== 1'b0) begin n_fail++; $display("FAIL rst_stale%0d valid got %b want 0", i, valid_out); end
        end
        n_checks++;
        if (ready_out !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after got %b want 1", ready_out); end
    endtask

    initial begin
        test_reset();
        test_single(9'd30,  4'd3,  32'h00008000, 32'h0000DDB4, "a30");
        test_single(9'd210, 4'd5,  32'hFFFF8000, 32'hFFFF224C, "a210");
        test_single(9'd400, 4'd9,  32'h0000A48E, 32'h0000C41B, "a400");
        test_single(9'd360, 4'd12, 32'h00000000, 32'h00010000, "a360");
        test_back_to_back();
        test_backpressure();
        test_reset_inflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
